// File: rtl/l1_write_buffer_if.sv
// Cache-side and memory-side signal bundle for the L1 write-through store buffer.
interface l1_write_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  occupancy;

  // Environment side: cache requester plus backing memory responder
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_ack, mem_rdata,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
           mem_req, mem_we, mem_addr, mem_wdata, full, empty, occupancy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_ack, mem_rdata,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
           mem_req, mem_we, mem_addr, mem_wdata, full, empty, occupancy
  );
endinterface

// File: rtl/l1_write_buffer.sv
// Write-through store buffer: FIFO of cache stores drained to memory, with read forwarding.
// Optional build macro WB_COALESCE_EN merges a store into a matching buffered entry.
module l1_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  l1_write_buffer_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TAG_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t            state, next_state;
  logic [TAG_W-1:0]  ent_tag  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_d;
  logic              full_q, empty_q;
  logic              rd_pend;
  logic [TAG_W-1:0]  pend_tag;

  logic              mem_req_q, mem_we_q, mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_resp_valid_q;
  logic [DATA_W-1:0] rd_resp_data_q;

  logic [TAG_W-1:0]  wr_tag, rd_tag;
  logic              wr_fire, rd_fire, rd_hit, rd_miss, push, pop;
  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;
  logic [DATA_W-1:0] rd_hit_data, head_data;
  logic              unused_offset_bits;

  function automatic logic [PTR_W-1:0] phys(input logic [PTR_W-1:0] base, input int unsigned k);
    return base + PTR_W'(k);
  endfunction

  assign wr_tag             = bus.wr_addr[ADDR_W-1:2];
  assign rd_tag             = bus.rd_addr[ADDR_W-1:2];
  assign unused_offset_bits = ^{bus.wr_addr[1:0], bus.rd_addr[1:0]};

  assign bus.wr_ready = !full_q || coal_hit;
  assign bus.rd_ready = (state != READ) && !rd_pend;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign rd_fire      = bus.rd_valid && bus.rd_ready;
  assign push         = wr_fire && !coal_hit;
  assign rd_miss      = rd_fire && !rd_hit;

  // Forwarding search, oldest to newest so the newest match wins; a same-cycle store is newest of all
  always_comb begin
    rd_hit      = 1'b0;
    rd_hit_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (ent_tag[phys(head, k)] == rd_tag)) begin
        rd_hit      = 1'b1;
        rd_hit_data = ent_data[phys(head, k)];
      end
    end
    if (wr_fire && (wr_tag == rd_tag)) begin
      rd_hit      = 1'b1;
      rd_hit_data = bus.wr_data;
    end
  end

`ifdef WB_COALESCE_EN
  // The head being drained is excluded so the in-flight write data stays stable
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) && !((k == 0) && (state == DRAIN)) &&
          (ent_tag[phys(head, k)] == wr_tag)) begin
        coal_hit = 1'b1;
        coal_idx = phys(head, k);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  // Head data as it will be after this edge, in case a store merges into it while idle
  assign head_data = (wr_fire && coal_hit && (coal_idx == head)) ? bus.wr_data : ent_data[head];

  assign count_d = count + CNT_W'(push) - CNT_W'(pop);

  // Next state and next memory-request fields
  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state)
      IDLE: begin
        if (rd_pend) begin
          next_state = READ;
          mem_addr_d = {pend_tag, 2'b00};
        end else if (rd_miss) begin
          next_state = READ;
          mem_addr_d = {rd_tag, 2'b00};
        end else if (count != '0) begin
          next_state  = DRAIN;
          mem_addr_d  = {ent_tag[head], 2'b00};
          mem_wdata_d = head_data;
        end
      end
      DRAIN: begin
        if (bus.mem_ack) begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      READ: begin
        if (bus.mem_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    mem_req_d = (next_state != IDLE);
    mem_we_d  = (next_state == DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      rd_pend         <= 1'b0;
      pend_tag        <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      rd_resp_valid_q <= 1'b0;
      rd_resp_data_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_tag[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      state       <= next_state;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count       <= count_d;
      full_q      <= (count_d == CNT_W'(DEPTH));
      empty_q     <= (count_d == '0);

      if (push) begin
        ent_tag[tail]  <= wr_tag;
        ent_data[tail] <= bus.wr_data;
        tail           <= tail + PTR_W'(1);
      end
      if (wr_fire && coal_hit) ent_data[coal_idx] <= bus.wr_data;
      if (pop) head <= head + PTR_W'(1);

      rd_resp_valid_q <= 1'b0;
      if (rd_fire && rd_hit) begin
        rd_resp_valid_q <= 1'b1;
        rd_resp_data_q  <= rd_hit_data;
      end
      if (rd_miss) begin
        rd_pend  <= 1'b1;
        pend_tag <= rd_tag;
      end
      if ((state == READ) && bus.mem_ack) begin
        rd_resp_valid_q <= 1'b1;
        rd_resp_data_q  <= bus.mem_rdata;
        rd_pend         <= 1'b0;
      end
    end
  end

  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.rd_resp_valid = rd_resp_valid_q;
  assign bus.rd_resp_data  = rd_resp_data_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.occupancy     = count;
endmodule

// File: tb/tb_l1_write_buffer.sv
// Directed self-checking bench for l1_write_buffer (DEPTH=4, 32-bit address/data).
module tb_l1_write_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  l1_write_buffer_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();

  l1_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  // Wait (bounded) for a memory request, capture it, then acknowledge after `delay` cycles
  task automatic mem_cycle(input int unsigned delay, input logic [31:0] rdata,
                           output logic [31:0] addr, output logic we, output logic [31:0] wdata);
    int unsigned waited = 0;
    while (!bus.mem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("mem_req_seen", 64'(bus.mem_req), 64'd1);
    addr  = bus.mem_addr;
    we    = bus.mem_we;
    wdata = bus.mem_wdata;
    repeat (delay) @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd;
    logic        we;
    logic        stale;

    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
    bus.mem_ack  = 1'b0; bus.mem_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_empty",     64'(bus.empty),         64'd1);
    check("rst_full",      64'(bus.full),          64'd0);
    check("rst_occ",       64'(bus.occupancy),     64'd0);
    check("rst_mem_req",   64'(bus.mem_req),       64'd0);
    check("rst_wr_ready",  64'(bus.wr_ready),      64'd1);
    check("rst_rd_ready",  64'(bus.rd_ready),      64'd1);
    check("rst_rd_resp",   64'(bus.rd_resp_valid), 64'd0);

    // Fill to full while memory stalls; head drain must hold steady
    write(32'h10, 32'hAAAA_0001);
    write(32'h14, 32'hBBBB_0002);
    write(32'h18, 32'hCCCC_0003);
    write(32'h1C, 32'hDDDD_0004);
    check("full_flag",     64'(bus.full),      64'd1);
    check("full_wr_ready", 64'(bus.wr_ready),  64'd0);
    check("full_occ",      64'(bus.occupancy), 64'd4);
    check("full_empty",    64'(bus.empty),     64'd0);
    repeat (2) @(negedge clk);
    check("drain_req",   64'(bus.mem_req),   64'd1);
    check("drain_we",    64'(bus.mem_we),    64'd1);
    check("drain_addr",  64'(bus.mem_addr),  64'h10);
    check("drain_wdata", 64'(bus.mem_wdata), 64'hAAAA_0001);
    mem_cycle(0, 32'h0, a, we, wd);
    check("pop_occ",     64'(bus.occupancy), 64'd3);
    check("pop_full",    64'(bus.full),      64'd0);
    check("gap_req",     64'(bus.mem_req),   64'd0);
    mem_cycle(0, 32'h0, a, we, wd);
    check("drain2_addr",  64'(a),  64'h14);
    check("drain2_wdata", 64'(wd), 64'hBBBB_0002);
    mem_cycle(0, 32'h0, a, we, wd);
    check("drain3_addr",  64'(a),  64'h18);
    mem_cycle(0, 32'h0, a, we, wd);
    check("drain4_wdata", 64'(wd), 64'hDDDD_0004);
    check("drained_empty", 64'(bus.empty), 64'd1);

    // Forwarding picks the newest duplicate; the head drain is unaffected
    write(32'h20, 32'h11);
    write(32'h24, 32'h22);
    write(32'h20, 32'h33);
    check("fwd_rd_ready", 64'(bus.rd_ready), 64'd1);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 32'h22;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    check("fwd_valid",      64'(bus.rd_resp_valid), 64'd1);
    check("fwd_data",       64'(bus.rd_resp_data),  64'h33);
    check("fwd_drain_addr", 64'(bus.mem_addr),      64'h20);
    check("fwd_drain_data", 64'(bus.mem_wdata),     64'h11);
    check("fwd_occ",        64'(bus.occupancy),     64'd3);
    @(negedge clk);
    check("fwd_pulse_end",  64'(bus.rd_resp_valid), 64'd0);
    mem_cycle(0, 32'h0, a, we, wd);
    mem_cycle(0, 32'h0, a, we, wd);
    check("fwd_d2_addr", 64'(a), 64'h24);
    mem_cycle(0, 32'h0, a, we, wd);
    check("fwd_d3_addr",  64'(a),  64'h20);
    check("fwd_d3_wdata", 64'(wd), 64'h33);

    // Read miss on an empty buffer, memory answers three cycles later
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 32'h41;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    check("miss_rd_ready", 64'(bus.rd_ready), 64'd0);
    check("miss_req",      64'(bus.mem_req),  64'd1);
    check("miss_we",       64'(bus.mem_we),   64'd0);
    check("miss_addr",     64'(bus.mem_addr), 64'h40);
    repeat (2) @(negedge clk);
    check("miss_wait_ready", 64'(bus.rd_ready),      64'd0);
    check("miss_wait_resp",  64'(bus.rd_resp_valid), 64'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    check("miss_resp_valid", 64'(bus.rd_resp_valid), 64'd1);
    check("miss_resp_data",  64'(bus.rd_resp_data),  64'hDEAD_BEEF);
    check("miss_done_ready", 64'(bus.rd_ready),      64'd1);
    check("miss_done_req",   64'(bus.mem_req),       64'd0);

    // Miss during a drain jumps ahead of the remaining buffered write
    write(32'h60, 32'h1111);
    write(32'h64, 32'h2222);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 32'h80;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    check("prio_rd_ready", 64'(bus.rd_ready), 64'd0);
    mem_cycle(0, 32'h0, a, we, wd);
    check("prio_d1_addr", 64'(a),  64'h60);
    check("prio_d1_we",   64'(we), 64'd1);
    mem_cycle(1, 32'hCAFE_F00D, a, we, wd);
    check("prio_rd_addr",   64'(a),                  64'h80);
    check("prio_rd_we",     64'(we),                 64'd0);
    check("prio_rd_valid",  64'(bus.rd_resp_valid),  64'd1);
    check("prio_rd_data",   64'(bus.rd_resp_data),   64'hCAFE_F00D);
    mem_cycle(0, 32'h0, a, we, wd);
    check("prio_d2_addr",  64'(a),  64'h64);
    check("prio_d2_wdata", 64'(wd), 64'h2222);

    // Same-cycle store and read to the same word forwards the store data
    bus.wr_valid = 1'b1; bus.wr_addr = 32'hA0; bus.wr_data = 32'h5555;
    bus.rd_valid = 1'b1; bus.rd_addr = 32'hA3;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    check("same_cyc_valid", 64'(bus.rd_resp_valid), 64'd1);
    check("same_cyc_data",  64'(bus.rd_resp_data),  64'h5555);
    mem_cycle(0, 32'h0, a, we, wd);
    check("same_cyc_drain_we", 64'(we), 64'd1);
    check("same_cyc_drain",    64'(a),  64'hA0);

    // Asynchronous reset in the middle of a drain
    write(32'h90, 32'h9);
    write(32'h94, 32'hA);
    write(32'h98, 32'hB);
    check("pre_rst_req", 64'(bus.mem_req),   64'd1);
    check("pre_rst_occ", 64'(bus.occupancy), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req",   64'(bus.mem_req),   64'd0);
    check("async_rst_occ",   64'(bus.occupancy), 64'd0);
    check("async_rst_empty", 64'(bus.empty),     64'd1);
    @(negedge clk);
    reset = 1'b0;
    stale = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_req) stale = 1'b1;
    end
    check("no_stale_drain", 64'(stale),         64'd0);
    check("post_rst_occ",   64'(bus.occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/l1_write_buffer.md
Name: l1_write_buffer

Overview:
Write-through store buffer between the L1 cache controller and backing memory. It queues cache store traffic in a FIFO and drains it to memory over a single req/ack channel. It also services cache line-fill reads, forwarding the newest buffered data on an address match and otherwise fetching from memory, with reads given priority over drains.

Parameters:
DEPTH, 4, number of buffer entries (power of 2, >=2)
ADDR_W, 32, byte address width
DATA_W, 32, word width

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-high
wr_valid  input  1  store request from cache
wr_ready  output  1  store accepted when wr_valid&&wr_ready
wr_addr  input  ADDR_W  store byte address
wr_data  input  DATA_W  store data
rd_valid  input  1  line-fill read request
rd_ready  output  1  read accepted when rd_valid&&rd_ready
rd_addr  input  ADDR_W  read byte address
rd_resp_valid  output  1  one-cycle pulse, read data valid
rd_resp_data  output  DATA_W  read data
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1=write, 0=read
mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wdata  output  DATA_W  write data
mem_ack  input  1  memory completes the request this cycle
mem_rdata  input  DATA_W  read data, valid with mem_ack
full  output  1  occupancy==DEPTH
empty  output  1  occupancy==0
occupancy  output  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset value of every output is 0, except wr_ready=1, rd_ready=1 and empty=1. Reset clears all entries, pointers and rd_pend, and sets state to IDLE. An in-flight memory transaction is abandoned; mem_req drops at reset.
- All address compares use addr[ADDR_W-1:2]; byte offset is ignored.
- Writes: wr_ready = !full (combinational on registered count). An accepted write goes to the tail at the clock edge. Occupancy does not change when a push and a pop occur in the same cycle. There is no push when full, even if a pop occurs that cycle.
- States: IDLE, DRAIN, READ.
- IDLE: if rd_pend is set or a read miss is accepted this cycle, go to READ. Otherwise, if !empty (pre-push), go to DRAIN. Otherwise stay in IDLE.
- DRAIN: mem_req=1, mem_we=1, addr/data = head entry, all held stable. On mem_ack, pop head and go to IDLE. A drain is never preempted.
- READ: mem_req=1, mem_we=0, mem_addr=pending read address. On mem_ack, rd_resp_data<=mem_rdata, rd_resp_valid=1 next cycle, clear rd_pend, go to IDLE.
- mem_req is registered and deasserts the cycle after ack, giving at least one idle cycle between transactions.
- Reads: rd_ready = (state!=READ) && !rd_pend. On acceptance, rd_addr is compared against all valid entries, including the head being drained.
  - Match: rd_resp_data = data of the newest matching entry; rd_resp_valid pulses the next cycle (latency 1). There is no memory access.
  - Same-cycle write with equal address: the write is ordered first, so wr_data is forwarded.
  - Miss: latch address and set rd_pend. Memory read is issued from IDLE on the next cycle, or after the current drain's ack. The read goes ahead of remaining buffered writes.
- Writes accepted after a pending read to the same address do not affect that read; it returns memory data.
- Only one read is outstanding at a time.

Optional Feature:
WB_COALESCE_EN
- Defined: an accepted write whose address matches a valid entry overwrites that entry's data in place, with no occupancy change. wr_ready = !full || coalesce_match. A match against the head while in DRAIN does not coalesce; the write allocates a new entry. At most one valid entry per address, except the draining head.
- Undefined: every write allocates. Duplicate addresses are allowed and forwarding selects the newest.

Test Plan:
- Reset -> empty=1, full=0, occupancy=0, mem_req=0, wr_ready=1, rd_ready=1, rd_resp_valid=0.
- DEPTH=4, mem_ack=0; write 0x10=A, 0x14=B, 0x18=C, 0x1C=D -> full=1, wr_ready=0, occupancy=4; mem_req=1, mem_we=1, mem_addr=0x10, mem_wdata=A stable. Pulse mem_ack -> occupancy=3, next request addr 0x14.
- mem_ack=0; write 0x20=0x11, 0x24=0x22, 0x20=0x33; read 0x20 -> next cycle rd_resp_valid=1, rd_resp_data=0x33; mem_req continues draining 0x20/0x11. With WB_COALESCE_EN, occupancy=3 (head not coalesced).
- Empty buffer; read 0x40; ack 3 cycles later with 0xDEADBEEF -> mem_we=0, mem_addr=0x40; rd_resp_valid one cycle after ack, rd_resp_data=0xDEADBEEF; rd_ready=0 until then.
- Two writes queued, drain of the first in progress; read 0x80 (miss) -> after drain ack, a READ to 0x80 is issued before the second write drains; response correct.
- Reset asserted mid-DRAIN with 3 entries -> mem_req=0 immediately, occupancy=0; no stale drain after release.
